// File: rtl/parity_rr_scheduler_if.sv
// parity_rr_scheduler_if: requester <-> parity scheduler handshake bundle
interface parity_rr_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 12
);
  localparam int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic                    odd_mode;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic                    done;
  logic                    parity_out;
  logic [ID_W-1:0]         done_id;
  modport master (output req, data, odd_mode, input gnt, busy, done, parity_out, done_id);
  modport slave  (input req, data, odd_mode, output gnt, busy, done, parity_out, done_id);
endinterface

// File: rtl/parity_rr_scheduler.sv
// parity_rr_scheduler: round-robin access to a serial 3-bit-per-cycle XOR parity stage
module parity_rr_scheduler #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 12
) (
  input logic clk,
  input logic rst_n,
  parity_rr_scheduler_if.slave bus
);
  localparam int CYC  = (DATA_W + 2) / 3;
  localparam int PW   = 3 * CYC;
  localparam int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW   = CYC > 1 ? $clog2(CYC) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state;
  logic [PW-1:0]   sreg;
  logic [CW-1:0]   cnt;
  logic            acc;
  logic            acc_next;
  logic            odd_q;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] cur;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] hi_win;
  logic [ID_W-1:0] lo_win;
  logic            hi;
  logic [N_REQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic            parity_out;
  logic [ID_W-1:0] done_id;
  assign acc_next = acc ^ (^sreg[2:0]);
  // Requests above the pointer win over those at or below it; lowest index first in each group.
  always_comb begin
    hi_win = '0;
    lo_win = '0;
    hi     = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (i > int'(last)) begin
          hi_win = ID_W'(i);
          hi     = 1'b1;
        end else begin
          lo_win = ID_W'(i);
        end
      end
    end
    win = hi ? hi_win : lo_win;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_out <= 1'b0;
      done_id    <= '0;
      last       <= ID_W'(N_REQ - 1);
      cur        <= '0;
      sreg       <= '0;
      acc        <= 1'b0;
      odd_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          sreg  <= PW'(bus.data[win*DATA_W +: DATA_W]);
          odd_q <= bus.odd_mode;
          acc   <= 1'b0;
          cnt   <= '0;
          gnt   <= N_REQ'(1) << win;
          busy  <= 1'b1;
          last  <= win;
          cur   <= win;
          state <= RUN;
        end
        RUN: begin
          acc  <= acc_next;
          sreg <= sreg >> 3;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(CYC - 1)) begin
            parity_out <= acc_next ^ odd_q;
            done_id    <= cur;
            done       <= 1'b1;
            gnt        <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.gnt        = gnt;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.parity_out = parity_out;
  assign bus.done_id    = done_id;
endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb_parity_rr_scheduler: directed vector table plus multi-cycle corner sequences
module tb_parity_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int passed = 0;
  int total = 0;
  parity_rr_scheduler_if #(.N_REQ(4), .DATA_W(12)) bus ();
  parity_rr_scheduler #(.N_REQ(4), .DATA_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  req;
    logic [47:0] data;
    logic        odd;
    logic [3:0]  gnt;
    logic        par;
    logic [1:0]  id;
  } vec_t;
  vec_t vt[8];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Grant, hold for 4 cycles while the inputs are scrambled, then check the done cycle.
  task automatic run_word(input string nm, input logic [3:0] r, input logic [47:0] d, input logic o,
                          input logic [3:0] eg, input logic ep, input logic [1:0] eid);
    int bad;
    @(negedge clk);
    bus.req = r;
    bus.data = d;
    bus.odd_mode = o;
    @(negedge clk);
    check({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
    bus.req = '0;
    bus.data = d ^ 48'h001001001001;
    bus.odd_mode = ~o;
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.gnt !== eg || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    check({nm, "_hold"}, 32'(bad), 0);
    @(negedge clk);
    check({nm, "_done"}, {29'd0, bus.done, bus.busy, |bus.gnt}, 32'h4);
    check({nm, "_parity"}, 32'(bus.parity_out), 32'(ep));
    check({nm, "_id"}, 32'(bus.done_id), 32'(eid));
  endtask
  initial begin
    int bad;
    int n;
    logic [3:0] exp_par;
    vt[0] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hA5C}, 1'b0, 4'b0001, 1'b0, 2'd0};
    vt[1] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hA5C}, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[2] = '{4'b0010, {12'h000, 12'h000, 12'h001, 12'h000}, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[3] = '{4'b0011, {12'h000, 12'h000, 12'h001, 12'hFFF}, 1'b0, 4'b0001, 1'b0, 2'd0};
    vt[4] = '{4'b0011, {12'h000, 12'h000, 12'h001, 12'hFFF}, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[5] = '{4'b1100, {12'h007, 12'h000, 12'h000, 12'h000}, 1'b1, 4'b0100, 1'b1, 2'd2};
    vt[6] = '{4'b1100, {12'h007, 12'h000, 12'h000, 12'h000}, 1'b0, 4'b1000, 1'b1, 2'd3};
    vt[7] = '{4'b1111, {12'h007, 12'h000, 12'h001, 12'hA5C}, 1'b0, 4'b0001, 1'b0, 2'd0};
    rst_n = 1'b0;
    bus.req = '0;
    bus.data = '0;
    bus.odd_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {bus.gnt, bus.busy, bus.done, bus.parity_out, bus.done_id}, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 0);
    run_word("pulse_req3", 4'b1000, {12'h007, 36'h0}, 1'b0, 4'b1000, 1'b1, 2'd3);
    for (int i = 0; i < 8; i++)
      run_word($sformatf("vec%0d", i), vt[i].req, vt[i].data, vt[i].odd, vt[i].gnt, vt[i].par, vt[i].id);
    // All four request at once and each drops on its grant.
    do_reset();
    @(negedge clk);
    bus.data = {12'h007, 12'h000, 12'h001, 12'hFFF};
    bus.odd_mode = 1'b0;
    bus.req = 4'b1111;
    exp_par = 4'b1010;
    n = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      if (bus.done === 1'b1 && n < 4) begin
        check($sformatf("all4_cycle%0d", n), 32'(c), 32'(5 * (n + 1)));
        check($sformatf("all4_id%0d", n), 32'(bus.done_id), 32'(n));
        check($sformatf("all4_par%0d", n), 32'(bus.parity_out), 32'(exp_par[n]));
        n++;
      end
    end
    check("all4_count", 32'(n), 4);
    // req0 and req2 re-raise right after their own done: strict alternation, no gaps.
    do_reset();
    @(negedge clk);
    bus.data = {12'h000, 12'h003, 12'h000, 12'hA5C};
    bus.req = 4'b0101;
    n = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      if (bus.done === 1'b1) begin
        check($sformatf("alt_cycle%0d", n), 32'(c), 32'(5 * (n + 1)));
        check($sformatf("alt_id%0d", n), 32'(bus.done_id), (n % 2) ? 2 : 0);
        n++;
        if (n < 5) bus.req[bus.done_id] = 1'b1;
      end
    end
    check("alt_count", 32'(n), 6);
    // Reset in the middle of a word aborts it and restores the pointer.
    do_reset();
    run_word("pre_abort", 4'b0010, {24'h0, 12'h001, 12'h0}, 1'b0, 4'b0010, 1'b1, 2'd1);
    @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    check("abort_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_out", {bus.gnt, bus.busy, bus.done, bus.parity_out, bus.done_id}, 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("abort_no_done", 32'(bad), 0);
    run_word("post_abort", 4'b1001, {12'h007, 24'h0, 12'hA5C}, 1'b0, 4'b0001, 1'b0, 2'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
